int_ctrl: RTL and testbench

Interrupt controller that shares the single PicoBlaze `interrupt` line among up to eight interrupt sources, typically the `int_out` outputs of `inport_ioc` instances in the gio subsystem. It masks and prioritises the sources and raises the CPU interrupt. It exposes status, mask and vector registers on the PicoBlaze port bus. It returns a one-cycle `int_ack` to the serviced source only when firmware writes end-of-interrupt (EOI).

---
 rtl/int_ctrl_pkg.sv | 31 +++
 rtl/int_prio_enc.sv | 29 ++
 rtl/int_ctrl.sv | 157 +++++++++++++++
 tb/tb_int_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/int_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// int_ctrl_pkg
// Shared definitions for the interrupt controller:
//   - default PicoBlaze port IDs of the STAT / MASK / VEC registers
//   - FSM state encodings (3-bit)
//   - position of the busy flag inside the VEC register
//   - helper that packs the VEC read word
// -----------------------------------------------------------------------------
package int_ctrl_pkg;

    localparam logic [7:0] DEF_ADDR_STAT = 8'h20;
    localparam logic [7:0] DEF_ADDR_MASK = 8'h21;
    localparam logic [7:0] DEF_ADDR_VEC  = 8'h22;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ASSERT  = 3'd1;
    localparam logic [2:0] ST_SERVICE = 3'd2;
    localparam logic [2:0] ST_ACK     = 3'd3;
    localparam logic [2:0] ST_GUARD   = 3'd4;

    localparam int VEC_BUSY_BIT = 7;

    // VEC = {busy, 4'b0, idx[2:0]}
    function automatic logic [7:0] vec_word(input logic busy, input logic [2:0] idx);
        logic [7:0] w;
        w               = {5'b0, idx};
        w[VEC_BUSY_BIT] = busy;
        return w;
    endfunction

endpackage

// File: rtl/int_prio_enc.sv
// -----------------------------------------------------------------------------
// int_prio_enc
// Lowest-index-wins priority encoder over N_SRC request lines.
// Ports:
//   req   in  N_SRC  request vector
//   valid out 1      at least one request is set
//   idx   out 3      index of the lowest set request (0 when none)
// -----------------------------------------------------------------------------
module int_prio_enc #(
    parameter int N_SRC = 4
) (
    input  logic [N_SRC-1:0] req,
    output logic             valid,
    output logic [2:0]       idx
);

    // Scan from the top down so the last hit, i.e. the lowest index, wins.
    always_comb begin
        valid = 1'b0;
        idx   = 3'd0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                idx   = 3'(i);
            end
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// -----------------------------------------------------------------------------
// int_ctrl
// Shares the single PicoBlaze interrupt line among up to eight level sources.
// Sources are masked, the lowest pending index is latched as the winner and
// the CPU is interrupted. The winner is acknowledged (src_ack pulse) only when
// firmware writes end-of-interrupt to the VEC register.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   address         PicoBlaze port_id
//   data_in         PicoBlaze out_port
//   data_out        read data, 8'h00 when nothing of this block is read
//   ren, wen        read / write strobes
//   src_int         level requests from the sources
//   src_ack         one-hot, one-cycle acknowledge to the serviced source
//   cpu_int         PicoBlaze interrupt (registered)
//   cpu_int_ack     PicoBlaze interrupt_ack
//   dbg_state       current FSM state (debug visibility)
//
// Bus handshake: a register access happens in every cycle its strobe is
// high while address matches; reads are combinational, writes are sampled on
// the rising clock edge. There is no back-pressure.
// -----------------------------------------------------------------------------
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int         N_SRC     = 4,
    parameter logic [7:0] ADDR_STAT = DEF_ADDR_STAT,
    parameter logic [7:0] ADDR_MASK = DEF_ADDR_MASK,
    parameter logic [7:0] ADDR_VEC  = DEF_ADDR_VEC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       address,
    input  logic [7:0]       data_in,
    output logic [7:0]       data_out,
    input  logic             ren,
    input  logic             wen,
    input  logic [N_SRC-1:0] src_int,
    output logic [N_SRC-1:0] src_ack,
    output logic             cpu_int,
    input  logic             cpu_int_ack,
    output logic [2:0]       dbg_state
);

    // Implemented MASK bits; bits at and above N_SRC stay 0.
    localparam logic [7:0]       MASK_BITS = 8'((1 << N_SRC) - 1);
    localparam logic [N_SRC-1:0] ACK_ONE   = N_SRC'(1);

    logic [2:0]       state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       mask_q;
    logic             cpu_int_q, cpu_int_d;
    logic [N_SRC-1:0] src_ack_q, src_ack_d;

    logic [N_SRC-1:0] pend;
    logic             win_valid;
    logic [2:0]       win_idx;
    logic             eoi_wr;
    logic             mask_wr;
    logic             busy;

    assign pend    = src_int & mask_q[N_SRC-1:0];
    assign eoi_wr  = wen && (address == ADDR_VEC);
    assign mask_wr = wen && (address == ADDR_MASK);
    assign busy    = (state_q != ST_IDLE);

    int_prio_enc #(
        .N_SRC (N_SRC)
    ) u_prio (
        .req   (pend),
        .valid (win_valid),
        .idx   (win_idx)
    );

    // ---------------- register bank ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_q <= 8'h00;
        end else if (mask_wr) begin
            mask_q <= data_in & MASK_BITS;
        end
    end

    always_comb begin
        data_out = 8'h00;
        if (ren) begin
            if (address == ADDR_STAT) begin
                data_out = 8'(src_int);
            end else if (address == ADDR_MASK) begin
                data_out = mask_q;
            end else if (address == ADDR_VEC) begin
                data_out = vec_word(busy, idx_q);
            end
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= 3'd0;
            cpu_int_q <= 1'b0;
            src_ack_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cpu_int_q <= cpu_int_d;
            src_ack_q <= src_ack_d;
        end
    end

    // ---------------- FSM: next state ----------------
    // The winner is latched only on the IDLE->ASSERT transition, so later
    // MASK or src_int changes cannot retarget the interrupt in flight.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (win_valid) begin
                    idx_d   = win_idx;
                    state_d = ST_ASSERT;
                end
            end
            ST_ASSERT: begin
                if (cpu_int_ack) begin
                    state_d = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                if (eoi_wr) begin
                    state_d = ST_ACK;
                end
            end
            ST_ACK:   state_d = ST_GUARD;
            ST_GUARD: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // Outputs are decoded from the next state and registered, so they line
    // up exactly with the state they belong to.
    always_comb begin
        cpu_int_d = (state_d == ST_ASSERT);
        src_ack_d = '0;
        if (state_d == ST_ACK) begin
            src_ack_d = ACK_ONE << idx_d;
        end
    end

    assign cpu_int   = cpu_int_q;
    assign src_ack   = src_ack_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_int_ctrl.sv
module tb_int_ctrl;

    localparam int         N      = 4;
    localparam logic [7:0] A_STAT = 8'h20;
    localparam logic [7:0] A_MASK = 8'h21;
    localparam logic [7:0] A_VEC  = 8'h22;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0]   address     = 8'h00;
    logic [7:0]   data_in     = 8'h00;
    logic [7:0]   data_out;
    logic         ren         = 1'b0;
    logic         wen         = 1'b0;
    logic [N-1:0] src_int     = '0;
    logic [N-1:0] src_ack;
    logic         cpu_int;
    logic         cpu_int_ack = 1'b0;
    logic [2:0]   dbg_state;

    int errors = 0;
    int checks = 0;
    logic chk_en = 1'b0;
    logic auto_clear = 1'b0;

    int_ctrl #(
        .N_SRC     (N),
        .ADDR_STAT (A_STAT),
        .ADDR_MASK (A_MASK),
        .ADDR_VEC  (A_VEC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .address     (address),
        .data_in     (data_in),
        .data_out    (data_out),
        .ren         (ren),
        .wen         (wen),
        .src_int     (src_int),
        .src_ack     (src_ack),
        .cpu_int     (cpu_int),
        .cpu_int_ack (cpu_int_ack),
        .dbg_state   (dbg_state)
    );

    // ---------------- reference model ----------------
    // Service progress: 0 idle, 1 interrupt raised, 2 in handler,
    // 3 acknowledging, 4 guard cycle.
    logic [7:0] m_mask = 8'h00;
    int         m_idx  = 0;
    int         m_step = 0;

    function automatic int lowest(input logic [N-1:0] p);
        for (int i = 0; i < N; i++) begin
            if (p[i]) return i;
        end
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mask <= 8'h00;
            m_idx  <= 0;
            m_step <= 0;
        end else begin
            case (m_step)
                0: if (lowest(src_int & m_mask[N-1:0]) >= 0) begin
                       m_idx  <= lowest(src_int & m_mask[N-1:0]);
                       m_step <= 1;
                   end
                1: if (cpu_int_ack) m_step <= 2;
                2: if (wen && address == A_VEC) m_step <= 3;
                3: m_step <= 4;
                default: m_step <= 0;
            endcase
            if (wen && address == A_MASK) m_mask <= {4'h0, data_in[N-1:0]};
        end
    end

    function automatic logic [7:0] model_read();
        if (!ren) return 8'h00;
        if (address == A_STAT) return {4'h0, src_int};
        if (address == A_MASK) return m_mask;
        if (address == A_VEC)  return {(m_step != 0), 4'b0, 3'(m_idx)};
        return 8'h00;
    endfunction

    // ---------------- scoreboard: every-cycle compare ----------------
    always @(negedge clk) begin
        logic         e_cpu;
        logic [N-1:0] e_ack;
        logic [7:0]   e_rd;
        if (chk_en) begin
            e_cpu = (m_step == 1);
            e_ack = (m_step == 3) ? N'(1 << m_idx) : '0;
            e_rd  = model_read();
            checks++;
            if (cpu_int !== e_cpu) begin
                errors++;
                $display("FAIL cyc_cpu_int t=%0t got=%b exp=%b", $time, cpu_int, e_cpu);
            end
            checks++;
            if (src_ack !== e_ack) begin
                errors++;
                $display("FAIL cyc_src_ack t=%0t got=%b exp=%b", $time, src_ack, e_ack);
            end
            checks++;
            if (data_out !== e_rd) begin
                errors++;
                $display("FAIL cyc_data_out t=%0t addr=%h got=%h exp=%h", $time, address, data_out, e_rd);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
        // A source drops its request once it has seen its acknowledge.
        if (auto_clear) src_int = src_int & ~src_ack;
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        wen = 1'b1; address = a; data_in = d;
        step();
        wen = 1'b0; address = 8'h00; data_in = 8'h00;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
        ren = 1'b1; address = a;
        #1;
        d = data_out;
        ren = 1'b0; address = 8'h00;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic service(input int exp_idx);
        cpu_int_ack = 1'b1;
        step();
        cpu_int_ack = 1'b0;
        check("svc_cpu_int_fall", {7'b0, cpu_int}, 8'h00);
        bus_write(A_VEC, 8'h5A);
        check("svc_ack_pulse", {4'h0, src_ack}, 8'(1 << exp_idx));
        step();
        check("svc_ack_single", {4'h0, src_ack}, 8'h00);
        step();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] rd;
        int op;

        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk_en = 1'b1;
        step();

        // reset state
        check("rst_cpu_int", {7'b0, cpu_int}, 8'h00);
        check("rst_src_ack", {4'h0, src_ack}, 8'h00);
        bus_read(A_MASK, rd); check("rst_mask", rd, 8'h00);
        bus_read(A_VEC, rd);  check("rst_vec", rd, 8'h00);

        // basic flow
        bus_write(A_MASK, 8'h01);
        src_int = 4'b0001;
        check("basic_cpu_int_pre", {7'b0, cpu_int}, 8'h00);
        step();
        check("basic_cpu_int_rise", {7'b0, cpu_int}, 8'h01);
        bus_read(A_VEC, rd); check("basic_vec", rd, 8'h80);
        auto_clear = 1'b1;
        service(0);
        step();
        bus_read(A_VEC, rd); check("basic_vec_done", rd, 8'h00);
        check("basic_no_reint", {7'b0, cpu_int}, 8'h00);

        // masking
        auto_clear = 1'b0;
        bus_write(A_MASK, 8'h00);
        src_int = 4'b1111;
        repeat (3) step();
        check("mask_cpu_int_low", {7'b0, cpu_int}, 8'h00);
        bus_read(A_STAT, rd); check("mask_stat", rd, 8'h0F);
        bus_write(A_MASK, 8'hF8);
        bus_read(A_MASK, rd); check("mask_upper_bits", rd, 8'h08);
        step();
        check("mask_cpu_int_rise", {7'b0, cpu_int}, 8'h01);
        bus_read(A_VEC, rd); check("mask_vec", rd, 8'h83);
        auto_clear = 1'b1;
        service(3);
        src_int = 4'b0000;
        step();

        // priority
        src_int = 4'b0110;
        bus_write(A_MASK, 8'h0F);
        step();
        bus_read(A_VEC, rd); check("prio_first_vec", rd, 8'h81);
        service(1);
        step();
        check("prio_second_int", {7'b0, cpu_int}, 8'h01);
        bus_read(A_VEC, rd); check("prio_second_vec", rd, 8'h82);
        service(2);
        step();
        check("prio_done", {7'b0, cpu_int}, 8'h00);

        // protocol abuse
        src_int = 4'b0000;
        cpu_int_ack = 1'b1;
        step();
        cpu_int_ack = 1'b0;
        check("abuse_ack_idle_int", {7'b0, cpu_int}, 8'h00);
        bus_read(A_VEC, rd); check("abuse_ack_idle_vec", rd, 8'h02);
        auto_clear = 1'b0;
        src_int = 4'b0001;
        step();
        bus_write(A_VEC, 8'h00);
        check("abuse_eoi_assert_int", {7'b0, cpu_int}, 8'h01);
        check("abuse_eoi_assert_ack", {4'h0, src_ack}, 8'h00);
        bus_read(A_VEC, rd); check("abuse_vec", rd, 8'h80);
        bus_read(8'h10, rd); check("abuse_unmapped", rd, 8'h00);

        // reset mid-service
        cpu_int_ack = 1'b1;
        step();
        cpu_int_ack = 1'b0;
        rst = 1'b1;
        #1;
        check("rstmid_cpu_int", {7'b0, cpu_int}, 8'h00);
        check("rstmid_src_ack", {4'h0, src_ack}, 8'h00);
        step();
        rst = 1'b0;
        step();
        bus_read(A_MASK, rd); check("rstmid_mask", rd, 8'h00);
        bus_read(A_VEC, rd);  check("rstmid_vec", rd, 8'h00);
        src_int = 4'b0000;
        step();

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) src_int = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 99) == 0) auto_clear = ~auto_clear;
            cpu_int_ack = ($urandom_range(0, 2) == 0);
            op = $urandom_range(0, 11);
            case (op)
                0, 1: begin wen = 1'b1; address = A_VEC; data_in = 8'($urandom); end
                2:    begin wen = 1'b1; address = A_MASK; data_in = 8'($urandom); end
                3:    begin wen = 1'b1; address = 8'($urandom); data_in = 8'($urandom); end
                4:    begin ren = 1'b1; address = A_STAT; end
                5:    begin ren = 1'b1; address = A_MASK; end
                6, 7: begin ren = 1'b1; address = A_VEC; end
                8:    begin ren = 1'b1; address = 8'($urandom); end
                default: ;
            endcase
            if ($urandom_range(0, 499) == 0) rst = 1'b1;
            step();
            wen = 1'b0; ren = 1'b0; address = 8'h00; data_in = 8'h00;
            cpu_int_ack = 1'b0;
            rst = 1'b0;
        end

        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
